// File: rtl/heap_sift_stage.sv
// One level of a pipelined binary-heap sift-down. A value arriving from the
// parent level is compared with its two children in this level's memory. The
// smaller of (value, smaller child) goes back up to the parent slot. If the
// value moved, it continues down to the child stage, or is stored directly
// when this is the deepest level.
module heap_sift_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LEVEL      = 1,
  parameter int LAST       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  // value sifting down from the parent stage
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_pos,
  // writeback into the parent level memory
  output logic                  up_valid,
  input  logic                  up_ready,
  output logic [ADDR_WIDTH-1:0] up_addr,
  output logic [DATA_WIDTH-1:0] up_data,
  // forward to the child stage
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pos,
  // child's writeback into this level
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  // level memory (combinational read, write on clk edge)
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  output logic                  ram_we_a,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_q_a,
  input  logic [DATA_WIDTH-1:0] ram_q_b,
  output logic                  init_done
);

  localparam int MEM_SIZE = 1 << LEVEL;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam bit IS_LAST = (LAST != 0);

  typedef enum logic [2:0] {
    INIT, IDLE, READ, CMP, UP, FWD, WAIT_WB
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;
  logic                    init_done_q, init_done_d;
  logic [DATA_WIDTH-1:0]   v_q, v_d;
  logic [ADDR_WIDTH-1:0]   p_q, p_d;
  logic [DATA_WIDTH-1:0]   qa_q, qa_d;
  logic [DATA_WIDTH-1:0]   qb_q, qb_d;
  logic [DATA_WIDTH-1:0]   up_data_q, up_data_d;
  logic [ADDR_WIDTH-1:0]   child_q, child_d;
  logic                    moved_q, moved_d;

  // Children of p sit at 2p and 2p+1, truncated to the address width.
  logic [ADDR_WIDTH-1:0] child_a, child_b;
  logic                  take_b;
  logic [DATA_WIDTH-1:0] min_val;
  assign child_a = p_q << 1;
  assign child_b = child_a | ADDR_WIDTH'(1);
  // Ties select child a, so only a strictly smaller b wins.
  assign take_b  = (qb_q < qa_q);
  assign min_val = take_b ? qb_q : qa_q;

  // State and datapath registers, forced back to the init sweep by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
      v_q         <= '0;
      p_q         <= '0;
      qa_q        <= '0;
      qb_q        <= '0;
      up_data_q   <= '0;
      child_q     <= '0;
      moved_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
      v_q         <= v_d;
      p_q         <= p_d;
      qa_q        <= qa_d;
      qb_q        <= qb_d;
      up_data_q   <= up_data_d;
      child_q     <= child_d;
      moved_q     <= moved_d;
    end
  end

  // Next-state and datapath capture.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_done_d = init_done_q;
    v_d         = v_q;
    p_d         = p_q;
    qa_d        = qa_q;
    qb_d        = qb_q;
    up_data_d   = up_data_q;
    child_d     = child_q;
    moved_d     = moved_q;
    case (state_q)
      INIT: begin
        if (init_addr_q == LAST_ADDR) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          init_addr_d = init_addr_q + ADDR_WIDTH'(1);
        end
      end
      IDLE: begin
        if (in_valid) begin
          v_d     = in_data;
          p_d     = in_pos;
          state_d = READ;
        end
      end
      READ: begin
        qa_d    = ram_q_a;
        qb_d    = ram_q_b;
        state_d = CMP;
      end
      CMP: begin
        // Strict compare: a value equal to the smaller child stays put,
        // which keeps an all-ones input from sinking past empty slots.
        moved_d   = (v_q > min_val);
        up_data_d = (v_q > min_val) ? min_val : v_q;
        child_d   = take_b ? child_b : child_a;
        state_d   = UP;
      end
      UP: begin
        if (up_ready) begin
          if (!moved_q || IS_LAST) state_d = IDLE;
          else                     state_d = FWD;
        end
      end
      FWD: begin
        if (out_ready) state_d = WAIT_WB;
      end
      WAIT_WB: begin
        if (wb_valid) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // Outputs decoded from state and registers; everything held low in reset.
  always_comb begin
    in_ready   = 1'b0;
    up_valid   = 1'b0;
    up_addr    = '0;
    up_data    = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_pos    = '0;
    wb_ready   = 1'b0;
    ram_addr_a = '0;
    ram_addr_b = '0;
    ram_data_a = '0;
    ram_data_b = '0;
    ram_we_a   = 1'b0;
    ram_we_b   = 1'b0;
    init_done  = 1'b0;
    if (!rst) begin
      init_done = init_done_q;
      up_addr   = p_q;
      up_data   = up_data_q;
      out_data  = v_q;
      out_pos   = child_q;
      case (state_q)
        INIT: begin
          ram_addr_a = init_addr_q;
          ram_data_a = '1;
          ram_we_a   = 1'b1;
        end
        IDLE: in_ready = 1'b1;
        READ: begin
          ram_addr_a = child_a;
          ram_addr_b = child_b;
        end
        UP: begin
          up_valid = 1'b1;
          // Deepest level: the displaced value lands in its child slot
          // in the same cycle the parent accepts the writeback.
          if (IS_LAST && moved_q && up_ready) begin
            ram_addr_a = child_q;
            ram_data_a = v_q;
            ram_we_a   = 1'b1;
          end
        end
        FWD: out_valid = 1'b1;
        WAIT_WB: begin
          wb_ready   = 1'b1;
          ram_addr_b = wb_addr;
          ram_data_b = wb_data;
          ram_we_b   = wb_valid;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_heap_sift_stage.sv
// Directed bench for heap_sift_stage (8-bit data, 2-bit address, level 2).
// Two instances: u0 with a child stage, u1 as the deepest level.
module tb_heap_sift_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---- instance 0 (LAST=0) ----
  logic       in_valid0, in_ready0, up_valid0, up_ready0, out_valid0, out_ready0;
  logic       wb_valid0, wb_ready0, ram_we_a0, ram_we_b0, init_done0;
  logic [7:0] in_data0, up_data0, out_data0, wb_data0, ram_data_a0, ram_data_b0, ram_q_a0, ram_q_b0;
  logic [1:0] in_pos0, up_addr0, out_pos0, wb_addr0, ram_addr_a0, ram_addr_b0;

  // ---- instance 1 (LAST=1) ----
  logic       in_valid1, in_ready1, up_valid1, up_ready1, out_valid1, out_ready1;
  logic       wb_valid1, wb_ready1, ram_we_a1, ram_we_b1, init_done1;
  logic [7:0] in_data1, up_data1, out_data1, wb_data1, ram_data_a1, ram_data_b1, ram_q_a1, ram_q_b1;
  logic [1:0] in_pos1, up_addr1, out_pos1, wb_addr1, ram_addr_a1, ram_addr_b1;

  heap_sift_stage #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .LEVEL(2), .LAST(0)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_pos(in_pos0),
    .up_valid(up_valid0), .up_ready(up_ready0), .up_addr(up_addr0), .up_data(up_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_pos(out_pos0),
    .wb_valid(wb_valid0), .wb_ready(wb_ready0), .wb_addr(wb_addr0), .wb_data(wb_data0),
    .ram_addr_a(ram_addr_a0), .ram_addr_b(ram_addr_b0), .ram_data_a(ram_data_a0),
    .ram_data_b(ram_data_b0), .ram_we_a(ram_we_a0), .ram_we_b(ram_we_b0),
    .ram_q_a(ram_q_a0), .ram_q_b(ram_q_b0), .init_done(init_done0)
  );

  heap_sift_stage #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .LEVEL(2), .LAST(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_pos(in_pos1),
    .up_valid(up_valid1), .up_ready(up_ready1), .up_addr(up_addr1), .up_data(up_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_pos(out_pos1),
    .wb_valid(wb_valid1), .wb_ready(wb_ready1), .wb_addr(wb_addr1), .wb_data(wb_data1),
    .ram_addr_a(ram_addr_a1), .ram_addr_b(ram_addr_b1), .ram_data_a(ram_data_a1),
    .ram_data_b(ram_data_b1), .ram_we_a(ram_we_a1), .ram_we_b(ram_we_b1),
    .ram_q_a(ram_q_a1), .ram_q_b(ram_q_b1), .init_done(init_done1)
  );

  // Level memories: combinational read, port A wins when both write,
  // plus a bench load port used only while the stage is idle.
  logic [7:0] mem0 [4];
  logic [7:0] mem1 [4];
  logic       tb_we0, tb_we1;
  logic [1:0] tb_addr0, tb_addr1;
  logic [7:0] tb_data0, tb_data1;

  always @(posedge clk) begin
    if (ram_we_a0)      mem0[ram_addr_a0] <= ram_data_a0;
    else if (ram_we_b0) mem0[ram_addr_b0] <= ram_data_b0;
    else if (tb_we0)    mem0[tb_addr0]    <= tb_data0;
  end
  always @(posedge clk) begin
    if (ram_we_a1)      mem1[ram_addr_a1] <= ram_data_a1;
    else if (ram_we_b1) mem1[ram_addr_b1] <= ram_data_b1;
    else if (tb_we1)    mem1[tb_addr1]    <= tb_data1;
  end
  assign ram_q_a0 = mem0[ram_addr_a0];
  assign ram_q_b0 = mem0[ram_addr_b0];
  assign ram_q_a1 = mem1[ram_addr_a1];
  assign ram_q_b1 = mem1[ram_addr_b1];

  // Event counters watched across the whole run.
  int out_cnt0 = 0;
  int out_cnt1 = 0;
  int both_we  = 0;
  always @(negedge clk) begin
    if (out_valid0) out_cnt0++;
    if (out_valid1) out_cnt1++;
    if ((ram_we_a0 && ram_we_b0) || (ram_we_a1 && ram_we_b1)) both_we++;
  end

  // Scoreboard
  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t up_q[$];
  exp_t out_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load0(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we0 = 1'b1; tb_addr0 = a; tb_data0 = d;
    @(negedge clk);
    tb_we0 = 1'b0;
  endtask

  // One full sift through u0: expectations come from the bench memory image.
  task automatic xact0(input logic [7:0] v, input logic [1:0] p,
                       input int up_delay, input logic [7:0] wbd);
    logic [1:0] a_addr, b_addr, c_addr;
    logic [7:0] a, b, m;
    logic       moved;
    exp_t       e;
    int         n;
    int         out_before;
    a_addr = {p[0], 1'b0};
    b_addr = {p[0], 1'b1};
    a = mem0[a_addr];
    b = mem0[b_addr];
    if (b < a) begin m = b; c_addr = b_addr; end
    else       begin m = a; c_addr = a_addr; end
    moved = (v > m);
    up_q.push_back('{addr: p, data: (moved ? m : v)});
    if (moved) out_q.push_back('{addr: c_addr, data: v});
    out_before = out_cnt0;

    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready0), 32'd1);
    in_valid0 = 1'b1; in_data0 = v; in_pos0 = p;
    @(negedge clk);
    in_valid0 = 1'b0;
    chk("in_ready_busy", 32'(in_ready0), 32'd0);
    chk("read_addr_a", 32'(ram_addr_a0), 32'(a_addr));
    chk("read_addr_b", 32'(ram_addr_b0), 32'(b_addr));

    n = 0;
    while (!up_valid0 && n < 10) begin @(negedge clk); n++; end
    chk("up_seen", 32'(up_valid0), 32'd1);
    e = up_q.pop_front();
    chk("up_addr", 32'(up_addr0), 32'(e.addr));
    chk("up_data", 32'(up_data0), 32'(e.data));
    for (int k = 0; k < up_delay; k++) begin
      @(negedge clk);
      chk("up_hold_valid", 32'(up_valid0), 32'd1);
      chk("up_hold_data", 32'(up_data0), 32'(e.data));
    end
    up_ready0 = 1'b1;
    @(negedge clk);
    up_ready0 = 1'b0;

    if (moved) begin
      n = 0;
      while (!out_valid0 && n < 10) begin @(negedge clk); n++; end
      chk("out_seen", 32'(out_valid0), 32'd1);
      e = out_q.pop_front();
      chk("out_data", 32'(out_data0), 32'(e.data));
      chk("out_pos", 32'(out_pos0), 32'(e.addr));
      chk("wb_ready_fwd", 32'(wb_ready0), 32'd0);
      out_ready0 = 1'b1;
      @(negedge clk);
      out_ready0 = 1'b0;
      chk("wb_ready_wait", 32'(wb_ready0), 32'd1);
      wb_valid0 = 1'b1; wb_addr0 = e.addr; wb_data0 = wbd;
      #1;
      chk("wb_we_b", 32'(ram_we_b0), 32'd1);
      chk("wb_we_a", 32'(ram_we_a0), 32'd0);
      chk("wb_addr_b", 32'(ram_addr_b0), 32'(e.addr));
      chk("wb_data_b", 32'(ram_data_b0), 32'(wbd));
      @(negedge clk);
      wb_valid0 = 1'b0;
      chk("wb_mem", 32'(mem0[e.addr]), 32'(wbd));
    end else begin
      chk("no_out_valid", 32'(out_valid0), 32'd0);
      chk("no_out_count", 32'(out_cnt0 - out_before), 32'd0);
    end
    chk("back_idle", 32'(in_ready0), 32'd1);
    $display("xact0 v=%0d p=%0d moved=%0d done", v, p, moved);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid0 = 0; in_data0 = 0; in_pos0 = 0; up_ready0 = 0; out_ready0 = 0;
    wb_valid0 = 0; wb_addr0 = 0; wb_data0 = 0; tb_we0 = 0; tb_addr0 = 0; tb_data0 = 0;
    in_valid1 = 0; in_data1 = 0; in_pos1 = 0; up_ready1 = 0; out_ready1 = 0;
    wb_valid1 = 0; wb_addr1 = 0; wb_data1 = 0; tb_we1 = 0; tb_addr1 = 0; tb_data1 = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready0), 32'd0);
    chk("rst_we_a", 32'(ram_we_a0), 32'd0);
    chk("rst_init_done", 32'(init_done0), 32'd0);
    chk("rst_up_valid", 32'(up_valid1), 32'd0);
    $display("reset state checked");

    // Init sweep: 0xFF to 0..3 on consecutive cycles
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      chk("sweep_we", 32'(ram_we_a0), 32'd1);
      chk("sweep_addr", 32'(ram_addr_a0), 32'(i));
      chk("sweep_data", 32'(ram_data_a0), 32'hFF);
      chk("sweep_done_low", 32'(init_done0), 32'd0);
    end
    @(negedge clk);
    chk("init_done", 32'(init_done0), 32'd1);
    chk("init_in_ready", 32'(in_ready0), 32'd1);
    chk("init_done_last", 32'(init_done1), 32'd1);
    for (int i = 0; i < 4; i++) chk("sweep_mem", 32'(mem0[i]), 32'hFF);
    $display("init sweep checked");

    // wb_valid outside WAIT_WB is ignored
    chk("wb_ready_idle", 32'(wb_ready0), 32'd0);
    wb_valid0 = 1'b1; wb_addr0 = 2'd1; wb_data0 = 8'h33;
    #1;
    chk("wb_ignored", 32'(ram_we_b0), 32'd0);
    @(negedge clk);
    wb_valid0 = 1'b0;
    $display("idle wb ignore checked");

    // Not moved, moved with writeback, tie, sentinel, truncated children
    load0(2'd2, 8'd10);
    load0(2'd3, 8'd20);
    xact0(8'd5, 2'd1, 0, 8'd0);
    xact0(8'd30, 2'd1, 0, 8'd12);
    load0(2'd2, 8'd7);
    load0(2'd3, 8'd7);
    xact0(8'd9, 2'd1, 3, 8'd8);
    xact0(8'hFF, 2'd0, 0, 8'd0);
    xact0(8'd9, 2'd3, 1, 8'd1);

    // Deepest level: displaced value stored on port A at the up handshake
    @(negedge clk);
    tb_we1 = 1'b1; tb_addr1 = 2'd2; tb_data1 = 8'd10;
    @(negedge clk);
    tb_addr1 = 2'd3; tb_data1 = 8'd20;
    @(negedge clk);
    tb_we1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 8'd30; in_pos1 = 2'd1;
    @(negedge clk);
    in_valid1 = 1'b0;
    n = 0;
    while (!up_valid1 && n < 10) begin @(negedge clk); n++; end
    chk("last_up_seen", 32'(up_valid1), 32'd1);
    chk("last_up_addr", 32'(up_addr1), 32'd1);
    chk("last_up_data", 32'(up_data1), 32'd10);
    chk("last_no_we_early", 32'(ram_we_a1), 32'd0);
    up_ready1 = 1'b1;
    #1;
    chk("last_we_a", 32'(ram_we_a1), 32'd1);
    chk("last_we_b", 32'(ram_we_b1), 32'd0);
    chk("last_addr_a", 32'(ram_addr_a1), 32'd2);
    chk("last_data_a", 32'(ram_data_a1), 32'd30);
    @(negedge clk);
    up_ready1 = 1'b0;
    chk("last_mem", 32'(mem1[2]), 32'd30);
    chk("last_idle", 32'(in_ready1), 32'd1);
    chk("last_no_out", 32'(out_cnt1), 32'd0);
    $display("last-level store checked");

    // Reset while waiting in FWD
    load0(2'd2, 8'd10);
    load0(2'd3, 8'd20);
    @(negedge clk);
    in_valid0 = 1'b1; in_data0 = 8'd30; in_pos0 = 2'd1;
    @(negedge clk);
    in_valid0 = 1'b0;
    n = 0;
    while (!up_valid0 && n < 10) begin @(negedge clk); n++; end
    chk("fwdrst_up_seen", 32'(up_valid0), 32'd1);
    up_ready0 = 1'b1;
    @(negedge clk);
    up_ready0 = 1'b0;
    chk("fwdrst_in_fwd", 32'(out_valid0), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_gate_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_gate_out_data", 32'(out_data0), 32'd0);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_up_valid0", 32'(up_valid0), 32'd0);
    chk("rst_wb_ready", 32'(wb_ready0), 32'd0);
    chk("rst_done_low", 32'(init_done0), 32'd0);
    rst = 1'b0;
    #1;
    chk("resweep_we", 32'(ram_we_a0), 32'd1);
    chk("resweep_addr0", 32'(ram_addr_a0), 32'd0);
    chk("resweep_out_valid", 32'(out_valid0), 32'd0);
    @(negedge clk);
    chk("resweep_addr1", 32'(ram_addr_a0), 32'd1);
    repeat (4) @(negedge clk);
    chk("resweep_done", 32'(init_done0), 32'd1);
    $display("reset in FWD checked");

    chk("never_both_we", 32'(both_we), 32'd0);
    chk("sb_empty", 32'(up_q.size() + out_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/heap_sift_stage.md
HEAP_SIFT_STAGE -- requirements
Module: heap_sift_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, key/value width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, level-memory address width (>= LEVEL).
REQ-003 SHALL have parameter LEVEL, default 1, heap level served (>= 1); level memory holds MEM_SIZE = 2^LEVEL entries.
REQ-004 SHALL have parameter LAST, default 0, 1 = deepest level (no child stage).
REQ-005 SHALL have one clock; reset is synchronous and active-high: clk input 1 (all logic on rising edge); rst input 1 (synchronous, active-high).
REQ-006 SHALL have ports: in_valid in 1, in_ready out 1, in_data in DATA_WIDTH (value v sifting down), in_pos in ADDR_WIDTH (parent position p at level LEVEL-1).
REQ-007 SHALL have ports: up_valid out 1, up_ready in 1, up_addr out ADDR_WIDTH, up_data out DATA_WIDTH (writeback into parent level memory).
REQ-008 SHALL have ports: out_valid out 1, out_ready in 1, out_data out DATA_WIDTH, out_pos out ADDR_WIDTH (forward to child stage).
REQ-009 SHALL have ports: wb_valid in 1, wb_ready out 1, wb_addr in ADDR_WIDTH, wb_data in DATA_WIDTH (child's up channel into this level).
REQ-010 SHALL have level-memory master ports: ram_addr_a/ram_addr_b out ADDR_WIDTH, ram_data_a/ram_data_b out DATA_WIDTH, ram_we_a/ram_we_b out 1, ram_q_a/ram_q_b in DATA_WIDTH (combinational read, write at clk edge).
REQ-011 SHALL have init_done out 1, high once the memory sweep is complete.

Function
REQ-012 SHALL implement FSM states INIT, IDLE, READ, CMP, UP, FWD, WAIT_WB.
REQ-013 INIT SHALL write all-ones (empty sentinel) to addresses 0..MEM_SIZE-1, one per cycle on port A, then go to IDLE (MEM_SIZE cycles).
REQ-014 SHALL never assert ram_we_a and ram_we_b in the same cycle (memory honours only port A then).
REQ-015 in_ready SHALL be 1 only in IDLE; handshake latches v and p, goes to READ.
REQ-016 READ SHALL drive ram_addr_a = 2p, ram_addr_b = 2p+1 (truncated to ADDR_WIDTH), we = 0, register qa, qb; then CMP.
REQ-017 CMP SHALL compute unsigned m = min(qa,qb), c = 1 only if qb < qa (tie selects a), moved = (v > m); then UP.
REQ-018 UP SHALL hold up_valid = 1, up_addr = p, up_data = (moved ? m : v) stable until up_ready.
REQ-019 On up handshake: not moved -> IDLE; moved and LAST=0 -> FWD; moved and LAST=1 -> same cycle write v to 2p+c on port A, then IDLE.
REQ-020 FWD SHALL hold out_valid = 1, out_data = v, out_pos = 2p+c until out_ready, then WAIT_WB.
REQ-021 WAIT_WB SHALL assert wb_ready = 1; on wb_valid write wb_data to wb_addr via port B in that cycle, then IDLE.
REQ-022 wb_ready SHALL be 0 in all states except WAIT_WB; wb_valid elsewhere is ignored.
REQ-023 Outputs SHALL be registered or decoded from state only; no combinational path from in_valid to in_ready.
REQ-024 Sentinel all-ones input SHALL be treated as a normal value (never moved past equal sentinel).

Reset
REQ-025 rst SHALL, at any state including mid-operation, force INIT, restart sweep at address 0, init_done = 0.
REQ-026 Under reset: in_ready, up_valid, out_valid, wb_ready, ram_we_a, ram_we_b = 0; data/address outputs = 0.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, LEVEL=2)
REQ-027 Release rst -> port A writes 0xFF to addresses 0,1,2,3 on four consecutive cycles; init_done and in_ready = 1 next cycle.
REQ-028 Memory[2]=10, [3]=20; in v=5, p=1 -> up(addr 1, data 5); out_valid never asserted; returns to IDLE.
REQ-029 Same memory, v=30, p=1 -> up(1,10), then out(30, pos 2), then wb(2,12) -> port B writes 12 to addr 2; IDLE.
REQ-030 Memory[2]=[3]=7, v=9, p=1 -> up data 7, out_pos 2 (tie picks a).
REQ-031 LAST=1, memory 10/20, v=30, p=1 -> port A writes 30 to addr 2 in up-handshake cycle; out_valid stays 0.
REQ-032 up_ready low 3 cycles -> up_valid/up_data stable; rst asserted in FWD -> next cycle all valids 0, sweep restarts at address 0.
